ccff_loader: RTL and testbench



---
 rtl/ccff_pkg.sv | 24 ++
 rtl/ccff_readback_cap.sv | 55 +++++
 rtl/ccff_loader.sv | 120 ++++++++++++
 tb/tb_ccff_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types for the configuration-chain loader: FSM state, debug view,
// and the bitstream word width also used by the bitstream DMA.
package ccff_pkg;

    localparam int unsigned CCFF_WORD_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } ccff_state_t;

    typedef struct packed {
        ccff_state_t state;
        logic        tail;
    } ccff_dbg_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned ccff_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccff_readback_cap.sv
// Tail deserialiser: packs bits leaving the chain MSB-first into words and
// emits a left-aligned, zero-padded partial word when flushed.
module ccff_readback_cap
    import ccff_pkg::*;
#(
    parameter int unsigned WORD_W = CCFF_WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic              sample_bit,
    input  logic              flush,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] cap_q;
    logic [WORD_W-1:0] cap_nxt;
    logic [WORD_W-1:0] aligned;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  pad;
    logic              emit;

    always_comb begin
        cap_nxt = (cap_q << 1) | WORD_W'(sample_bit);
        cnt_nxt = cnt_q + 1'b1;
        pad     = CNT_W'(WORD_W) - cnt_nxt;
        aligned = cap_nxt << pad;
        emit    = sample_en & ((cnt_nxt == CNT_W'(WORD_W)) | flush);
    end

    // Collector is cleared on every emit so a partial word never carries stale bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q    <= '0;
            cnt_q    <= '0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
        end else begin
            rb_valid <= emit;
            if (emit) begin
                rb_data <= aligned;
                cap_q   <= '0;
                cnt_q   <= '0;
            end else if (sample_en) begin
                cap_q <= cap_nxt;
                cnt_q <= cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Serialises bitstream words MSB-first into the configuration chain head.
// Define CCFF_LOADER_READBACK_EN to add tail capture (rb_valid/rb_data).
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int unsigned WORD_W    = CCFF_WORD_W_DEFAULT,
    parameter int unsigned CHAIN_LEN = 1024
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
`ifdef CCFF_LOADER_READBACK_EN
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
`endif
    output ccff_dbg_t         dbg
);

    // Stream handshake: a word moves on a prog_clk edge where s_valid and
    // s_ready are both high; s_ready depends only on state, never on s_valid.

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = ccff_idx_w(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    ccff_state_t       state_q;
    ccff_state_t       state_nxt;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [WORD_W-1:0] sreg_q;
    logic              in_shift;
    logic              last_word_bit;
    logic              last_chain_bit;
    logic              accept;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state_q;
        in_shift       = (state_q == SHIFT);
        last_word_bit  = (bit_idx_q == LAST_IDX);
        last_chain_bit = (bit_cnt_q == LAST_BIT);
        busy           = (state_q != IDLE);
        done           = (state_q == FINISH);
        ccff_shift_en  = in_shift;
        ccff_head      = in_shift & sreg_q[WORD_W-1];
        // Refill is offered on a word's last bit only if chain bits remain.
        s_ready        = (state_q == FETCH) | (in_shift & last_word_bit & ~last_chain_bit);
        accept         = s_valid & s_ready;
        case (state_q)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH:  if (s_valid) state_nxt = SHIFT;
            SHIFT: begin
                if (last_chain_bit) begin
                    state_nxt = FINISH;
                end else if (last_word_bit) begin
                    state_nxt = s_valid ? SHIFT : FETCH;
                end
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter only advances in SHIFT, so it stops at CHAIN_LEN and never wraps.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            sreg_q    <= '0;
        end else begin
            if ((state_q == IDLE) && start) begin
                bit_cnt_q <= '0;
                bit_idx_q <= '0;
            end
            if (in_shift) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (accept) begin
                sreg_q    <= s_data;
                bit_idx_q <= '0;
            end else if (in_shift) begin
                sreg_q    <= sreg_q << 1;
                bit_idx_q <= bit_idx_q + 1'b1;
            end
        end
    end

    assign dbg = {state_q, ccff_tail};

`ifdef CCFF_LOADER_READBACK_EN
    ccff_readback_cap #(
        .WORD_W (WORD_W)
    ) u_readback_cap (
        .clk        (prog_clk),
        .rst_n      (prog_reset_n),
        .sample_en  (ccff_shift_en),
        .sample_bit (ccff_tail),
        .flush      (ccff_shift_en & last_chain_bit),
        .rb_valid   (rb_valid),
        .rb_data    (rb_data)
    );
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: table of 40-bit loads against a behavioural
// chain model, plus hand sequences for reset, idle offers and CHAIN_LEN=1.
module tb_ccff_loader;
    import ccff_pkg::*;

    localparam int W = 32;
    localparam int L = 40;

    // ---------------- clock / reset ----------------
    logic prog_clk     = 1'b0;
    logic prog_reset_n = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // main DUT (CHAIN_LEN=40)
    logic         start   = 1'b0;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_data  = '0;
    logic         busy, done, s_ready, ccff_head, ccff_shift_en, ccff_tail;
    ccff_dbg_t    dbg;
`ifdef CCFF_LOADER_READBACK_EN
    logic         rb_valid;
    logic [W-1:0] rb_data;
`endif

    // single-bit chain DUT
    logic         start1   = 1'b0;
    logic         s_valid1 = 1'b0;
    logic [W-1:0] s_data1  = '0;
    logic         tail1    = 1'b0;
    logic         busy1, done1, s_ready1, head1, en1;
    ccff_dbg_t    dbg1;
`ifdef CCFF_LOADER_READBACK_EN
    logic         rb_valid1;
    logic [W-1:0] rb_data1;
`endif

    ccff_loader #(.WORD_W(W), .CHAIN_LEN(L)) u_dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
`ifdef CCFF_LOADER_READBACK_EN
        .rb_valid      (rb_valid),
        .rb_data       (rb_data),
`endif
        .dbg           (dbg)
    );

    ccff_loader #(.WORD_W(W), .CHAIN_LEN(1)) u_one (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start1),
        .busy          (busy1),
        .done          (done1),
        .s_valid       (s_valid1),
        .s_ready       (s_ready1),
        .s_data        (s_data1),
        .ccff_head     (head1),
        .ccff_shift_en (en1),
        .ccff_tail     (tail1),
`ifdef CCFF_LOADER_READBACK_EN
        .rb_valid      (rb_valid1),
        .rb_data       (rb_data1),
`endif
        .dbg           (dbg1)
    );

    // behavioural 40-bit configuration chain
    logic [L-1:0] chain       = '0;
    logic [L-1:0] preload_val = '0;
    logic         preload_req = 1'b0;
    always @(posedge prog_clk) begin
        if (preload_req) chain <= preload_val;
        else if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
    end
    assign ccff_tail = chain[L-1];

    // ---------------- scoreboard ----------------
    logic [0:0]   exp_q[$];
    logic [W-1:0] rb_exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; withholds s_valid for `stall` cycles in which
    // s_ready is high, then holds it until the word is taken.
    task automatic offer(input logic [W-1:0] w, input int stall);
        int held = 0;
        bit acc  = 1'b0;
        s_data = w;
        for (int g = 0; g < 200; g++) begin
            s_valid = (held >= stall);
            if (s_valid && s_ready) begin
                @(negedge prog_clk);
                acc = 1'b1;
                break;
            end
            if (s_ready) held++;
            @(negedge prog_clk);
        end
        s_valid = 1'b0;
        check("offer_accepted", acc, 1);
    endtask

    typedef struct {
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        int           stall;
        int           restart_at;
        logic [L-1:0] preload;
        logic [L-1:0] exp_chain;
        int           exp_lat;
        int           exp_en;
    } vec_t;

    vec_t vecs[5];

    task automatic run_row(input vec_t v, input int id);
        int k        = 0;
        int lat      = -1;
        int en_cnt   = 0;
        int gap_cnt  = 0;
        int busy_low = 0;
        bit seen_en  = 1'b0;
        bit got_done = 1'b0;
        logic [0:0] e;
        exp_q.delete();
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(v.w0[i]);
        for (int i = W - 1; i >= W - 8; i--) exp_q.push_back(v.w1[i]);
        rb_exp_q.delete();
        rb_exp_q.push_back(v.preload[L-1:8]);
        rb_exp_q.push_back({v.preload[7:0], 24'h0});
        @(negedge prog_clk);
        preload_val = v.preload;
        preload_req = 1'b1;
        @(negedge prog_clk);
        preload_req = 1'b0;
        fork
            begin
                start = 1'b1;
                @(negedge prog_clk);
                start = 1'b0;
                offer(v.w0, 0);
                offer(v.w1, v.stall);
            end
            begin
                if (v.restart_at > 0) begin
                    repeat (v.restart_at) @(negedge prog_clk);
                    start = 1'b1;
                    @(negedge prog_clk);
                    start = 1'b0;
                end
            end
            begin
                #1;
                while (!got_done && k < 300) begin
                    if (k >= 1 && !done && !busy) busy_low++;
                    if (ccff_shift_en) begin
                        en_cnt++;
                        seen_en = 1'b1;
                        check($sformatf("r%0d_head_q_nonempty", id), exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check($sformatf("r%0d_head_bit%0d", id, en_cnt - 1), ccff_head, e);
                        end
                    end else if (seen_en && !done) begin
                        gap_cnt++;
                    end
`ifdef CCFF_LOADER_READBACK_EN
                    if (rb_valid) begin
                        check($sformatf("r%0d_rb_q_nonempty", id), rb_exp_q.size() != 0, 1);
                        if (rb_exp_q.size() != 0) begin
                            check($sformatf("r%0d_rb_data", id), rb_data, rb_exp_q.pop_front());
                            if (rb_exp_q.size() == 0) check($sformatf("r%0d_rb_with_done", id), done, 1);
                        end
                    end
`endif
                    if (done) begin
                        got_done = 1'b1;
                        lat      = k;
                    end else begin
                        @(negedge prog_clk);
                        #1;
                        k++;
                    end
                end
            end
        join
        check($sformatf("r%0d_done_seen", id), got_done, 1);
        check($sformatf("r%0d_latency", id), lat, v.exp_lat);
        check($sformatf("r%0d_en_cycles", id), en_cnt, v.exp_en);
        check($sformatf("r%0d_stall_gap", id), gap_cnt, v.stall);
        check($sformatf("r%0d_busy_low", id), busy_low, 0);
        check($sformatf("r%0d_bits_left", id), exp_q.size(), 0);
        check($sformatf("r%0d_chain", id), chain, v.exp_chain);
`ifdef CCFF_LOADER_READBACK_EN
        check($sformatf("r%0d_rb_left", id), rb_exp_q.size(), 0);
`endif
        @(negedge prog_clk);
        check($sformatf("r%0d_done_pulse", id), done, 0);
        check($sformatf("r%0d_idle_busy", id), busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_head"}, ccff_head, 0);
        check({tag, "_shift_en"}, ccff_shift_en, 0);
        check({tag, "_state"}, dbg.state, IDLE);
`ifdef CCFF_LOADER_READBACK_EN
        check({tag, "_rb_valid"}, rb_valid, 0);
        check({tag, "_rb_data"}, rb_data, 0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{w0: 32'hA5A5A5A5, w1: 32'hFF000000, stall: 0, restart_at: 0,
                    preload: 40'h12345678_9A, exp_chain: 40'hA5A5A5A5_FF, exp_lat: 42, exp_en: 40};
        vecs[1] = '{w0: 32'hA5A5A5A5, w1: 32'hFF000000, stall: 5, restart_at: 0,
                    preload: 40'h0F0F0F0F_0F, exp_chain: 40'hA5A5A5A5_FF, exp_lat: 47, exp_en: 40};
        vecs[2] = '{w0: 32'hA5A5A5A5, w1: 32'hFF000000, stall: 0, restart_at: 10,
                    preload: 40'h80000000_01, exp_chain: 40'hA5A5A5A5_FF, exp_lat: 42, exp_en: 40};
        vecs[3] = '{w0: 32'h12345678, w1: 32'h9A5A5A5A, stall: 3, restart_at: 0,
                    preload: 40'hA5A5A5A5_FF, exp_chain: 40'h12345678_9A, exp_lat: 45, exp_en: 40};
        vecs[4] = '{w0: 32'hFFFFFFFF, w1: 32'h00FFFFFF, stall: 0, restart_at: 0,
                    preload: 40'h00000000_00, exp_chain: 40'hFFFFFFFF_00, exp_lat: 42, exp_en: 40};

        repeat (3) @(negedge prog_clk);
        check_all_zero("reset");
        check("one_reset_s_ready", s_ready1, 0);
        prog_reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_row(vecs[i], i);

        // words offered while idle are never taken
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge prog_clk);
            check($sformatf("idle_offer_ready%0d", i), s_ready, 0);
            check($sformatf("idle_offer_busy%0d", i), busy, 0);
        end
        s_valid = 1'b0;

        // asynchronous reset at bit 17 of a load
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hA5A5A5A5;
        @(negedge prog_clk);
        s_valid = 1'b0;
        repeat (17) @(negedge prog_clk);
        check("rst17_shift_en", ccff_shift_en, 1);
        check("rst17_head", ccff_head, 0);
        #1 prog_reset_n = 1'b0;
        #1;
        check_all_zero("rst17");
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        run_row(vecs[0], 10);

        // CHAIN_LEN=1: one enabled cycle, s_ready never reasserted
        @(negedge prog_clk);
        start1 = 1'b1;
        @(negedge prog_clk);
        start1   = 1'b0;
        s_valid1 = 1'b1;
        s_data1  = 32'h80000000;
        check("one_fetch_ready", s_ready1, 1);
        check("one_fetch_en", en1, 0);
        check("one_fetch_busy", busy1, 1);
        @(negedge prog_clk);
        s_data1 = 32'h00000000;
        check("one_shift_en", en1, 1);
        check("one_shift_head", head1, 1);
        check("one_shift_ready", s_ready1, 0);
        @(negedge prog_clk);
        check("one_done", done1, 1);
        check("one_done_en", en1, 0);
        check("one_done_ready", s_ready1, 0);
        @(negedge prog_clk);
        check("one_after_done", done1, 0);
        check("one_after_busy", busy1, 0);
        check("one_after_ready", s_ready1, 0);
        s_valid1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
